l4_elastic_register: RTL and testbench



---
 rtl/l4_elastic_register.sv | 92 +++++++++
 tb/tb_l4_elastic_register.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/l4_elastic_register.sv
// rtl/l4_elastic_register.sv - DEPTH-entry valid/ready elastic register stage (optional L4_ELASTIC_BYPASS_EN)
module l4_elastic_register #(
    parameter int NBITS = 8,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NBITS-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             bypass;
    logic             push;
    logic             pop;
    logic             store;
    logic             take;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status, handshakes and head word; in_ready depends on registered count only.
    always_comb begin
        full      = (cnt == CW'(DEPTH));
        empty     = (cnt == '0);
        in_ready  = !full;
`ifdef L4_ELASTIC_BYPASS_EN
        bypass    = empty && in_valid && out_ready && !flush && !reset;
`else
        bypass    = 1'b0;
`endif
        out_valid = !empty || bypass;
        if (bypass) begin
            out_data = in_data;
        end else if (empty) begin
            out_data = '0;
        end else begin
            out_data = mem[rd_ptr];
        end
        push  = in_valid && in_ready;
        pop   = out_valid && out_ready;
        // A bypassed word is consumed in flight and never touches storage.
        store = push && !bypass;
        take  = pop && !bypass;
        count = cnt;
    end

    // Pointers and occupancy; reset and flush discard everything, including this cycle's handshakes.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (take) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({store, take})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (store && !reset && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_l4_elastic_register.sv
// tb/tb_l4_elastic_register.sv - scoreboard bench for l4_elastic_register (NBITS=8, DEPTH=3)
module tb_l4_elastic_register;

    localparam int NBITS = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NBITS-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NBITS-1:0] out_data;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NBITS-1:0] q[$];

    l4_elastic_register #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: compare DUT against the queue model at negedge, update model, advance past posedge.
    task automatic step(input string tag, input bit check_state);
        bit               bp;
        bit               exp_valid;
        bit               accept;
        logic [NBITS-1:0] exp_head;
        @(negedge clk);
        bp = 1'b0;
`ifdef L4_ELASTIC_BYPASS_EN
        bp = (q.size() == 0) && in_valid && out_ready && !flush && !reset;
`endif
        exp_valid = (q.size() != 0) || bp;
        exp_head  = bp ? in_data : ((q.size() != 0) ? q[0] : '0);
        accept    = in_valid && (q.size() < DEPTH);
        if (check_state) begin
            chk({tag, ".count"},     32'(count),     32'(q.size()));
            chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
            chk({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
            chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
            chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
            chk({tag, ".out_data"},  32'(out_data),  32'(exp_head));
        end
        if (reset || flush) begin
            q.delete();
        end else begin
            if (accept) q.push_back(in_data);
            if (exp_valid && out_ready) void'(q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int cycles;

        // Reset for two cycles with in_valid high: nothing may be stored.
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
        step("reset0", 1'b0);
        step("reset1", 1'b1);
        reset = 1'b0; in_valid = 1'b0;
        step("post_reset", 1'b1);

        // Fill to full with downstream stalled, then attempt an extra push.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h11; step("fill0", 1'b1);
        in_data = 8'h22; step("fill1", 1'b1);
        in_data = 8'h33; step("fill2", 1'b1);
        in_data = 8'h44; step("full_hold0", 1'b1);
        step("full_hold1", 1'b1);
        chk("full_count", 32'(count), 32'(DEPTH));

        // Drain in order on consecutive cycles.
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step("drain", 1'b1);
        chk("drain_empty", 32'(empty), 32'd1);

        // Streaming with wrap at out_ready held high.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(i);
            step("stream", 1'b1);
        end
        in_valid = 1'b0;
        step("stream_tail", 1'b1);
        step("stream_idle", 1'b1);

        // Simultaneous push and pop at count 2.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hA1; step("pp_fill0", 1'b1);
        in_data = 8'hA2; step("pp_fill1", 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hB0 + 8'(i);
            step("pp_both", 1'b1);
        end
        chk("pp_count", 32'(count), 32'd2);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step("pp_drain", 1'b1);

        // Flush at count 2 with a concurrent push of 0xAA.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h61; step("fl_fill0", 1'b1);
        in_data = 8'h62; step("fl_fill1", 1'b1);
        flush = 1'b1; in_data = 8'hAA;
        step("flush", 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step("post_flush0", 1'b1);
        step("post_flush1", 1'b1);
        chk("flush_no_aa_valid", 32'(out_valid), 32'd0);

`ifdef L4_ELASTIC_BYPASS_EN
        // Bypass: empty + in_valid + out_ready passes through the same cycle.
        in_valid = 1'b1; in_data = 8'h5C; out_ready = 1'b1;
        step("bypass", 1'b1);
        chk("bypass_count_after", 32'(count), 32'd0);
        out_ready = 1'b0;
        step("bypass_stall", 1'b1);
        in_valid = 1'b0;
        step("bypass_stored", 1'b1);
        chk("bypass_stored_data", 32'(out_data), 32'h5C);
        out_ready = 1'b1;
        step("bypass_drain", 1'b1);
        step("bypass_idle", 1'b1);
`endif

        // Random traffic on both sides, 1000 words through the scoreboard.
        sent = 0;
        cycles = 0;
        while ((sent < 1000 || q.size() != 0) && cycles < 20000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            if (in_valid && q.size() < DEPTH) sent++;
            step("random", 1'b1);
            cycles++;
        end
        chk("random_sent", 32'(sent), 32'd1000);
        chk("random_drained", 32'(q.size()), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        step("final", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
